// File: rtl/scsp_timer_irq_pkg.sv
// Shared types and constants for the sound-processor timer/interrupt block.
// Widths, register map, timer register layout and level encoder.
package scsp_timer_irq_pkg;

    localparam int NUM_TIMERS = 3;
    localparam int CNT_W      = 8;
    localparam int CTL_W      = 3;
    localparam int NUM_SRC    = 11;
    localparam int TIMER_BASE = 6;
    localparam int MANUAL_BIT = 5;
    localparam int LV_ENTRIES = 8;

    localparam int ADDR_W = 5;
    localparam int DATA_W = 16;
    localparam int PRE_W  = (1 << CTL_W) - 1;

    typedef enum logic [ADDR_W-1:0] {
        R_TMR0   = '0,
        R_SCIEB  = ADDR_W'(NUM_TIMERS),
        R_SCIPD,
        R_SCIRE,
        R_SCILV0,
        R_SCILV1,
        R_SCILV2,
        R_MCIEB,
        R_MCIPD,
        R_MCIRE
    } reg_idx_e;

    typedef struct packed {
        logic [CTL_W-1:0] ctl;
        logic [CNT_W-1:0] cnt;
    } tmr_reg_t;

    typedef logic [NUM_SRC-1:0]    src_vec_t;
    typedef logic [LV_ENTRIES-1:0] lv_vec_t;

    localparam tmr_reg_t TMR_RST = '0;
    localparam src_vec_t SRC_RST = '0;
    localparam lv_vec_t  LV_RST  = '0;

    // Sources past the table end share its last entry.
    function automatic logic [2:0] lvl_enc(
        input src_vec_t pd,
        input src_vec_t en,
        input lv_vec_t  lv0,
        input lv_vec_t  lv1,
        input lv_vec_t  lv2
    );
        logic [2:0] best;
        logic [2:0] cur;
        int         k;
        best = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            k   = (i < LV_ENTRIES - 1) ? i : LV_ENTRIES - 1;
            cur = {lv2[k], lv1[k], lv0[k]};
            if (pd[i] && en[i] && cur > best)
                best = cur;
        end
        return best;
    endfunction

endpackage

// File: rtl/scsp_timer_irq_if.sv
// Register bus between the control register file and the timer/irq block.
// Word addressed, registered read data.
interface scsp_timer_irq_if;
    import scsp_timer_irq_pkg::*;

    logic [ADDR_W-1:0] reg_addr;
    logic              reg_we;
    logic [DATA_W-1:0] reg_di;
    logic [DATA_W-1:0] reg_do;

    modport master (
        output reg_addr, reg_we, reg_di,
        input  reg_do
    );

    modport slave (
        input  reg_addr, reg_we, reg_di,
        output reg_do
    );

endinterface

// File: rtl/scsp_timer.sv
// One sample-rate timer: 2^ctl prescaler feeding a free-running counter.
// ovf pulses in the cycle the counter wraps from all-ones to zero.
module scsp_timer
    import scsp_timer_irq_pkg::*;
(
    input  logic     clk,
    input  logic     rst,
    input  logic     ce,
    input  logic     sample_ce,
    input  logic     we,
    input  tmr_reg_t wdat,
    output tmr_reg_t rdat,
    output logic     ovf
);

    tmr_reg_t         r;
    logic [PRE_W-1:0] pre;
    logic [PRE_W-1:0] lim;
    logic             step;

    assign lim  = ~({PRE_W{1'b1}} << r.ctl);
    assign step = sample_ce && (pre == lim);

    always_ff @(posedge clk) begin
        if (rst) begin
            r   <= TMR_RST;
            pre <= '0;
        end else if (ce) begin
            if (we) begin
                r   <= wdat;
                pre <= '0;
            end else if (sample_ce) begin
                pre <= step ? '0 : pre + PRE_W'(1);
                if (step)
                    r.cnt <= r.cnt + CNT_W'(1);
            end
        end
    end

    // A write in the wrap cycle reloads the counter instead.
    assign ovf  = ce && !we && step && (&r.cnt);
    assign rdat = r;

endmodule

// File: rtl/scsp_timer_irq.sv
// Timers plus pending/enable/reset interrupt matrices for the sound CPU
// and main side; sound-CPU requests are encoded to a 3-bit level.
module scsp_timer_irq
    import scsp_timer_irq_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 ce,
    input  logic                 sample_ce,
    scsp_timer_irq_if.slave      bus,
    input  logic [NUM_SRC-1:0]   src_in,
    output logic [2:0]           scu_irq_lvl,
    output logic                 main_irq
);

    tmr_reg_t              tmr_rd [NUM_TIMERS];
    logic [NUM_TIMERS-1:0] tmr_we;
    logic [NUM_TIMERS-1:0] tmr_ovf;

    src_vec_t scieb, scipd, mcieb, mcipd, src_q;
    src_vec_t ovf_vec, edge_v;
    src_vec_t sc_set, sc_clr, mc_set, mc_clr;
    lv_vec_t  lv0, lv1, lv2;

    logic [DATA_W-1:0] rd;
    logic [DATA_W-1:0] do_q;
    logic              unused_di;

    assign unused_di = ^bus.reg_di[DATA_W-1:NUM_SRC];

    for (genvar t = 0; t < NUM_TIMERS; t++) begin : g_tmr
        assign tmr_we[t] = ce && bus.reg_we &&
                           (bus.reg_addr == ADDR_W'(t));
        scsp_timer u_tmr (
            .clk       (clk),
            .rst       (rst),
            .ce        (ce),
            .sample_ce (sample_ce),
            .we        (tmr_we[t]),
            .wdat      (bus.reg_di[CTL_W+CNT_W-1:0]),
            .rdat      (tmr_rd[t]),
            .ovf       (tmr_ovf[t])
        );
    end

    always_comb begin
        ovf_vec = '0;
        for (int t = 0; t < NUM_TIMERS; t++)
            ovf_vec[TIMER_BASE+t] = tmr_ovf[t];
    end

    assign edge_v = src_in & ~src_q;

    // Sets are OR-ed after the clear, so a same-cycle set wins.
    always_comb begin
        sc_set = ovf_vec | edge_v;
        mc_set = ovf_vec | edge_v;
        sc_clr = '0;
        mc_clr = '0;
        if (bus.reg_we) begin
            unique case (1'b1)
                bus.reg_addr == R_SCIPD:
                    sc_set[MANUAL_BIT] = sc_set[MANUAL_BIT] |
                                         bus.reg_di[MANUAL_BIT];
                bus.reg_addr == R_SCIRE:
                    sc_clr = bus.reg_di[NUM_SRC-1:0];
                bus.reg_addr == R_MCIPD:
                    mc_set[MANUAL_BIT] = mc_set[MANUAL_BIT] |
                                         bus.reg_di[MANUAL_BIT];
                bus.reg_addr == R_MCIRE:
                    mc_clr = bus.reg_di[NUM_SRC-1:0];
                default: ;
            endcase
        end
    end

    always_comb begin
        rd = '0;
        case (bus.reg_addr)
            R_SCIEB:  rd = DATA_W'(scieb);
            R_SCIPD:  rd = DATA_W'(scipd);
            R_SCILV0: rd = DATA_W'(lv0);
            R_SCILV1: rd = DATA_W'(lv1);
            R_SCILV2: rd = DATA_W'(lv2);
            R_MCIEB:  rd = DATA_W'(mcieb);
            R_MCIPD:  rd = DATA_W'(mcipd);
            default:  rd = '0;
        endcase
        for (int t = 0; t < NUM_TIMERS; t++)
            if (bus.reg_addr == ADDR_W'(t))
                rd = DATA_W'(tmr_rd[t]);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            scieb       <= SRC_RST;
            scipd       <= SRC_RST;
            mcieb       <= SRC_RST;
            mcipd       <= SRC_RST;
            src_q       <= SRC_RST;
            lv0         <= LV_RST;
            lv1         <= LV_RST;
            lv2         <= LV_RST;
            do_q        <= '0;
            scu_irq_lvl <= '0;
            main_irq    <= 1'b0;
        end else if (ce) begin
            src_q <= src_in;
            scipd <= (scipd & ~sc_clr) | sc_set;
            mcipd <= (mcipd & ~mc_clr) | mc_set;
            if (bus.reg_we) begin
                case (bus.reg_addr)
                    R_SCIEB:  scieb <= bus.reg_di[NUM_SRC-1:0];
                    R_SCILV0: lv0   <= bus.reg_di[LV_ENTRIES-1:0];
                    R_SCILV1: lv1   <= bus.reg_di[LV_ENTRIES-1:0];
                    R_SCILV2: lv2   <= bus.reg_di[LV_ENTRIES-1:0];
                    R_MCIEB:  mcieb <= bus.reg_di[NUM_SRC-1:0];
                    default: ;
                endcase
            end
            do_q        <= rd;
            scu_irq_lvl <= lvl_enc(scipd, scieb, lv0, lv1, lv2);
            main_irq    <= |(mcipd & mcieb);
        end
    end

    assign bus.reg_do = do_q;

endmodule
